// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional build macro: IFETCH_PERF_CNT_EN (fetch/stall/redirect counters).
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } ifetch_state_e;

  // What the fetch unit does this cycle while in RUN, already priority-resolved.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_REDIRECT,
    ACT_FAULT,
    ACT_STALL,
    ACT_HALT,
    ACT_FETCH
  } ifetch_act_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INCR,
    PC_LOAD
  } pc_sel_e;

  localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF   = 32'hFFFF_FFFF;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/instruction_fetch_ctrl_if.sv
// Fetch-side bus: hazard/redirect inputs, instruction memory port and IF/ID outputs.
// Optional build macro: IFETCH_PERF_CNT_EN adds the performance counter signals.
interface instruction_fetch_ctrl_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemInstruction;
  logic [31:0] ImemAddress;
  logic [31:0] PC;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPCPlus4;
  logic        IfIdValid;
  logic        Halted;
  logic        Fault;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
  logic [31:0] RedirectCount;

  modport master (
    input  Stall, Redirect, RedirectTarget, ImemInstruction,
    output ImemAddress, PC, IfIdInstruction, IfIdPCPlus4, IfIdValid, Halted, Fault,
    output FetchCount, StallCount, RedirectCount
  );
  modport slave (
    output Stall, Redirect, RedirectTarget, ImemInstruction,
    input  ImemAddress, PC, IfIdInstruction, IfIdPCPlus4, IfIdValid, Halted, Fault,
    input  FetchCount, StallCount, RedirectCount
  );
`else
  modport master (
    input  Stall, Redirect, RedirectTarget, ImemInstruction,
    output ImemAddress, PC, IfIdInstruction, IfIdPCPlus4, IfIdValid, Halted, Fault
  );
  modport slave (
    output Stall, Redirect, RedirectTarget, ImemInstruction,
    input  ImemAddress, PC, IfIdInstruction, IfIdPCPlus4, IfIdValid, Halted, Fault
  );
`endif
endinterface

// File: rtl/ifetch_pc_reg.sv
// PC register with redirect/increment/hold next-PC mux and fetch range compare.
module ifetch_pc_reg
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        out_of_range_o
);

  // One extra bit so a full 4 GiB memory limit does not overflow.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  logic [31:0] pc_q, pc_d;

  assign pc_plus4_o     = pc_q + 32'd4;
  assign out_of_range_o = ({1'b0, pc_q} >= PC_LIMIT);
  assign pc_o           = pc_q;

  always_comb begin
    // NOTE: default assignment first keeps this block latch-free on every path.
    pc_d = pc_q;
    unique case (sel_i)
      PC_INCR: pc_d = pc_plus4_o;
      PC_LOAD: pc_d = target_i & WORD_ALIGN_MASK;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational IMEM and fills IF/ID.
// Optional build macro: IFETCH_PERF_CNT_EN enables saturating fetch/stall/redirect counters.
module instruction_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  instruction_fetch_ctrl_if.master  bus
);

  ifetch_state_e state_q;
  ifetch_act_e   act;
  pc_sel_e       pc_sel;
  logic [31:0]   pc, pc_plus4;
  logic          out_of_range;
  logic [31:0]   ifid_instr_q, ifid_pc4_q;
  logic          ifid_valid_q, halted_q, fault_q;

  ifetch_pc_reg #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_reg (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .sel_i         (pc_sel),
    .target_i      (bus.RedirectTarget),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .out_of_range_o(out_of_range)
  );

  // Priority: redirect > range fault > stall > halt word > normal fetch.
  always_comb begin
    act    = ACT_NONE;
    pc_sel = PC_HOLD;
    if (state_q == RUN) begin
      if (bus.Redirect) begin
        act    = ACT_REDIRECT;
        pc_sel = PC_LOAD;
      end else if (out_of_range) begin
        act = ACT_FAULT;
      end else if (bus.Stall) begin
        act = ACT_STALL;
      end else if (bus.ImemInstruction == HALT_WORD) begin
        act = ACT_HALT;
      end else begin
        act    = ACT_FETCH;
        pc_sel = PC_INCR;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= BOOT;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (state_q == BOOT) state_q <= RUN;
      unique case (act)
        ACT_REDIRECT: begin
          ifid_instr_q <= NOP_WORD;
          ifid_valid_q <= 1'b0;
        end
        ACT_FAULT: begin
          ifid_instr_q <= NOP_WORD;
          ifid_valid_q <= 1'b0;
          fault_q      <= 1'b1;
          state_q      <= FAULT;
        end
        ACT_HALT: begin
          ifid_instr_q <= NOP_WORD;
          ifid_valid_q <= 1'b0;
          halted_q     <= 1'b1;
          state_q      <= HALT;
        end
        ACT_FETCH: begin
          ifid_instr_q <= bus.ImemInstruction;
          ifid_pc4_q   <= pc_plus4;
          ifid_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ImemAddress     = pc;
  assign bus.PC              = pc;
  assign bus.IfIdInstruction = ifid_instr_q;
  assign bus.IfIdPCPlus4     = ifid_pc4_q;
  assign bus.IfIdValid       = ifid_valid_q;
  assign bus.Halted          = halted_q;
  assign bus.Fault           = fault_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, redirect_cnt_q;

  // Only RUN produces these actions, so the counters freeze in HALT/FAULT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (act == ACT_FETCH && fetch_cnt_q != '1)       fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (act == ACT_STALL && stall_cnt_q != '1)       stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (act == ACT_REDIRECT && redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign bus.FetchCount    = fetch_cnt_q;
  assign bus.StallCount    = stall_cnt_q;
  assign bus.RedirectCount = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: directed scenarios plus random stall/redirect traffic
// against a cycle-level reference model; a second small-memory instance covers range faults.
module tb_instruction_fetch_ctrl;
  import ifetch_pkg::*;

  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W   = 32'h0000_0000;
  localparam int unsigned WORDS_A = 1024;
  localparam int unsigned WORDS_B = 8;

  logic Clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 Clk = ~Clk;

  instruction_fetch_ctrl_if ifa ();
  instruction_fetch_ctrl_if ifb ();

  logic [31:0] mem_a [WORDS_A];
  logic [31:0] mem_b [WORDS_B];

  assign ifa.ImemInstruction = (ifa.ImemAddress < WORDS_A * 4) ? mem_a[ifa.ImemAddress[11:2]]
                                                               : 32'hDEAD_BEEF;
  assign ifb.ImemInstruction = (ifb.ImemAddress < WORDS_B * 4) ? mem_b[ifb.ImemAddress[4:2]]
                                                               : 32'h1234_5678;

  instruction_fetch_ctrl #(.IMEM_WORDS(WORDS_A)) dut_a (.Clk(Clk), .Reset_n(rst_a), .bus(ifa));
  instruction_fetch_ctrl #(.IMEM_WORDS(WORDS_B)) dut_b (.Clk(Clk), .Reset_n(rst_b), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural view of the fetch unit, stepped once per clock.
  bit          m_booted, m_halted, m_fault, m_valid;
  logic [31:0] m_pc, m_instr, m_pc4;
  int unsigned m_fetches, m_stalls, m_redirects;

  task automatic model_reset();
    m_booted = 0; m_halted = 0; m_fault = 0; m_valid = 0;
    m_pc = 32'h0; m_instr = NOP_W; m_pc4 = 32'h0;
    m_fetches = 0; m_stalls = 0; m_redirects = 0;
  endtask

  task automatic model_step(input bit stall, input bit redir, input logic [31:0] tgt);
    logic [31:0] word;
    word = (m_pc < WORDS_A * 4) ? mem_a[m_pc / 4] : 32'hDEAD_BEEF;
    if (!m_booted) m_booted = 1;
    else if (!m_halted && !m_fault) begin
      if (redir) begin
        m_pc = tgt - (tgt % 4); m_valid = 0; m_instr = NOP_W; m_redirects++;
      end else if (m_pc >= WORDS_A * 4) begin
        m_fault = 1; m_valid = 0; m_instr = NOP_W;
      end else if (stall) begin
        m_stalls++;
      end else if (word == HALT_W) begin
        m_halted = 1; m_valid = 0; m_instr = NOP_W;
      end else begin
        m_instr = word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_fetches++;
      end
    end
  endtask

  task automatic compare_a(input string tag);
    check({tag, ":pc"},     ifa.PC,              m_pc);
    check({tag, ":addr"},   ifa.ImemAddress,     m_pc);
    check({tag, ":valid"},  32'(ifa.IfIdValid),  32'(m_valid));
    check({tag, ":halted"}, 32'(ifa.Halted),     32'(m_halted));
    check({tag, ":fault"},  32'(ifa.Fault),      32'(m_fault));
    check({tag, ":instr"},  ifa.IfIdInstruction, m_instr);
    if (m_valid) check({tag, ":pc4"}, ifa.IfIdPCPlus4, m_pc4);
`ifdef IFETCH_PERF_CNT_EN
    check({tag, ":fcnt"}, ifa.FetchCount,    m_fetches);
    check({tag, ":scnt"}, ifa.StallCount,    m_stalls);
    check({tag, ":rcnt"}, ifa.RedirectCount, m_redirects);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cycle_a(input bit stall, input bit redir, input logic [31:0] tgt);
    ifa.Stall = stall; ifa.Redirect = redir; ifa.RedirectTarget = tgt;
    model_step(stall, redir, tgt);
    @(posedge Clk);
    @(negedge Clk);
    compare_a("cyc");
  endtask

  task automatic reset_a();
    ifa.Stall = 0; ifa.Redirect = 0; ifa.RedirectTarget = 0;
    rst_a = 0;
    #1;
    model_reset();
    compare_a("rst");
    @(negedge Clk);
    rst_a = 1;
    compare_a("boot");
  endtask

  task automatic fill_linear();
    for (int i = 0; i < WORDS_A; i++) mem_a[i] = 32'(i * 3);
  endtask

  initial begin
    bit seen;
    ifb.Stall = 0; ifb.Redirect = 0; ifb.RedirectTarget = 0;
    for (int i = 0; i < WORDS_B; i++) mem_b[i] = 32'(i * 3);
    fill_linear();
    @(negedge Clk);

    // Free run from reset.
    reset_a();
    check("boot_valid", 32'(ifa.IfIdValid), 0);
    cycle_a(0, 0, 0);
    cycle_a(0, 0, 0);
    check("seq0_instr", ifa.IfIdInstruction, 0);
    check("seq0_pc4",   ifa.IfIdPCPlus4,     4);
    cycle_a(0, 0, 0);
    check("seq1_instr", ifa.IfIdInstruction, 3);
    check("seq1_pc4",   ifa.IfIdPCPlus4,     8);
    cycle_a(0, 0, 0);
    check("seq2_instr", ifa.IfIdInstruction, 6);
    check("seq2_pc4",   ifa.IfIdPCPlus4,     12);
    cycle_a(0, 0, 0);
    check("pc_after5",  ifa.PC, 32'h10);

    // Three-cycle stall at PC=0x8, then redirect colliding with a stall.
    reset_a();
    for (int i = 0; i < 3; i++) cycle_a(0, 0, 0);
    check("pre_stall_pc", ifa.PC, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle_a(1, 0, 0);
      check("stall_pc",    ifa.PC, 32'h8);
      check("stall_instr", ifa.IfIdInstruction, 3);
    end
    cycle_a(0, 0, 0);
    check("post_stall_instr", ifa.IfIdInstruction, 6);
    check("post_stall_pc",    ifa.PC, 32'hC);
    cycle_a(1, 1, 32'h43);
    check("redir_pc",    ifa.PC, 32'h40);
    check("redir_valid", 32'(ifa.IfIdValid), 0);
    cycle_a(0, 0, 0);
    check("redir_capture", ifa.IfIdInstruction, 48);

    // Halt word at word 5, ignored redirect, async reset out of HALT.
    mem_a[5] = HALT_W;
    reset_a();
    for (int i = 0; i < 7; i++) cycle_a(0, 0, 0);
    check("halt_flag", 32'(ifa.Halted), 1);
    check("halt_pc",   ifa.PC, 32'h14);
    cycle_a(0, 1, 32'h100);
    check("halt_ignore_redir", ifa.PC, 32'h14);
    #2;
    rst_a = 0;
    #1;
    check("halt_rst_halted", 32'(ifa.Halted), 0);
    check("halt_rst_pc",     ifa.PC, 32'h0);
    mem_a[5] = 32'd15;
    @(negedge Clk);

`ifdef IFETCH_PERF_CNT_EN
    reset_a();
    cycle_a(0, 0, 0);
    for (int i = 0; i < 5; i++) cycle_a(0, 0, 0);
    cycle_a(1, 0, 0);
    cycle_a(1, 0, 0);
    cycle_a(0, 1, 32'h0);
    for (int i = 0; i < 5; i++) cycle_a(0, 0, 0);
    check("perf_fetch",    ifa.FetchCount,    10);
    check("perf_stall",    ifa.StallCount,    2);
    check("perf_redirect", ifa.RedirectCount, 1);
`endif

    // Random traffic: random memory, sparse halt words, some out-of-range redirects.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < WORDS_A; i++)
        mem_a[i] = ($urandom_range(0, 127) == 0) ? HALT_W : ($urandom & 32'hFFFF_FFFE);
      reset_a();
      for (int c = 0; c < 250; c++) begin
        bit          st, rd;
        logic [31:0] tg;
        st = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 11) == 0);
        tg = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(4096, 8191)) : 32'($urandom_range(0, 4095));
        cycle_a(st, rd, tg);
      end
    end

    // Small memory: free run must fault at PC=0x20.
    @(negedge Clk);
    rst_b = 1;
    seen  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clk);
      seen = ifb.Fault;
    end
    check("b_fault_seen", 32'(seen), 1);
    check("b_fault_pc",   ifb.PC, 32'h20);
    check("b_fault_valid", 32'(ifb.IfIdValid), 0);
    check("b_fault_last", ifb.IfIdInstruction, NOP_W);
    for (int c = 0; c < 3; c++) @(negedge Clk);
    check("b_fault_pc_hold", ifb.PC, 32'h20);
    check("b_fault_hold",    32'(ifb.Fault), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_ctrl.md
Name: instruction_fetch_ctrl

Overview:
- Sequences the combinational, read-only instruction memory for the 5-stage MIPS pipeline.
- Owns the PC and drives the memory address each cycle.
- Captures the returned word into the IF/ID register.
- Handles hazard stalls, branch/jump redirects, a halt word and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; legal PC range is 0 to IMEM_WORDS*4-4.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000, bubble inserted into IF/ID.

Ports:
- Clk  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard unit request to hold PC and IF/ID.
- Redirect  input  1  branch/jump taken, resolved in a later stage.
- RedirectTarget  input  32  new fetch address.
- ImemInstruction  input  32  combinational read data from instruction memory.
- ImemAddress  output  32  byte address to instruction memory; always equals PC.
- PC  output  32  current fetch PC.
- IfIdInstruction  output  32  registered fetched word.
- IfIdPCPlus4  output  32  registered PC+4 of that word.
- IfIdValid  output  1  IF/ID holds a real instruction.
- Halted  output  1  fetch stopped by HALT_WORD.
- Fault  output  1  fetch stopped by an out-of-range PC.

Behaviour:
- Reset (async assert, any state): PC=RESET_PC, IfIdInstruction=NOP_WORD, IfIdPCPlus4=0, IfIdValid=0, Halted=0, Fault=0, state=BOOT.
- Deassertion is sampled synchronously at the next rising edge.
- States:
  - BOOT: one cycle, no capture, then go to RUN.
  - RUN: normal fetch.
  - HALT and FAULT: absorbing; exit only via reset.
- RUN, priority order per cycle:
  1. Redirect=1: PC <= {RedirectTarget[31:2],2'b00}. IF/ID <= NOP_WORD with IfIdValid=0. Overrides Stall.
  2. PC >= IMEM_WORDS*4: go to FAULT, Fault=1, IF/ID <= bubble, PC frozen.
  3. Stall=1: PC and all IF/ID registers hold.
  4. ImemInstruction==HALT_WORD: IF/ID <= bubble, PC holds, go to HALT, Halted=1.
  5. Otherwise: IfIdInstruction <= ImemInstruction, IfIdPCPlus4 <= PC+4, IfIdValid <= 1, PC <= PC+4.
- Latency: an instruction at address A appears on IF/ID one cycle after PC==A in an unstalled cycle.
- PC+4 is a modulo-2^32 add; wrap-around is caught by the range check on the following cycle.
- HALT/FAULT: Redirect and Stall are ignored. IfIdValid=0. ImemAddress stays at the frozen PC.
- Stall held for N cycles: IF/ID is stable for N cycles; no instruction is dropped or duplicated.
- Stall and Redirect in the same cycle: the redirect wins, and the stalled IF/ID content is discarded.
- All outputs are registered except ImemAddress, which mirrors the PC register.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined: adds outputs FetchCount[31:0] (increments on each step-5 capture), StallCount[31:0] (increments on each step-3 cycle) and RedirectCount[31:0] (increments on each step-1 cycle).
  - All three counters reset to 0, are saturating, and freeze in HALT/FAULT.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ifetch_pkg:
  - State enum {BOOT, RUN, HALT, FAULT}, 2 bits.
  - Default NOP_WORD and HALT_WORD constants.
  - Word-align helper constant 32'hFFFF_FFFC.
- One natural sub-module, ifetch_pc_reg: PC register, next-PC mux (redirect/+4/hold) and range compare.
- The FSM and IF/ID register stay in the top module.

Test Plan:
- Reset then run; memory[i]=i*3, no Stall/Redirect:
  - IfIdValid=0 during BOOT.
  - IF/ID then sequences 0,3,6 with IfIdPCPlus4 4,8,12.
  - PC=0x10 after 5 cycles.
- Stall=1 for 3 cycles while PC=0x8:
  - PC stays 0x8 and IfIdInstruction stays 3 for 3 cycles.
  - Next capture is 6, with no skip and no repeat.
- Redirect=1, RedirectTarget=0x43 at PC=0xC, Stall=1 same cycle:
  - Next cycle PC=0x40, IfIdValid=0.
  - The following capture is memory[16]=48.
- Place HALT_WORD at word 5:
  - Halted=1 after PC reaches 0x14 and PC stays 0x14.
  - A later Redirect is ignored.
  - Reset_n low mid-HALT immediately clears Halted, PC=0.
- IMEM_WORDS=8, free run: at PC=0x20, Fault=1 and IfIdValid=0; PC stays 0x20.
- With IFETCH_PERF_CNT_EN: 10 fetches, 2 stalls, 1 redirect give FetchCount=10, StallCount=2, RedirectCount=1.
